// File: rtl/uart_pkg.sv
// Shared defaults, glitch counter width and channel output bundle for the
// UART receive line filter bank.
package uart_pkg;

    localparam int DEF_CHANNELS    = 1;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 2;
    localparam int DEF_LO_THRESH   = 0;
    localparam int DEF_RESET_LEVEL = 1;
    localparam int GLITCH_W        = 8;

    typedef struct packed {
        logic out;
        logic rise;
        logic fall;
    } ch_out_t;

    function automatic int max_cnt(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/uart_rx_filter_ch.sv
// One filtered UART line: synchroniser, saturating deadband counter with
// hysteresis, edge pulses. Glitch counter exists only with UART_RX_FILTER_GLITCH_EN.
module uart_rx_filter_ch
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int HI_THRESH   = max_cnt(DEF_CNT_W),
    parameter int LO_THRESH   = DEF_LO_THRESH,
    parameter int RESET_LEVEL = DEF_RESET_LEVEL
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    samp_clk,
    input  logic    in,
`ifdef UART_RX_FILTER_GLITCH_EN
    input  logic                glitch_clr,
    output logic [GLITCH_W-1:0] glitch_cnt,
`endif
    output ch_out_t q
);

    localparam logic             RL    = (RESET_LEVEL != 0);
    localparam logic [CNT_W-1:0] MAX_C = '1;
    localparam logic [CNT_W-1:0] HI_C  = CNT_W'(HI_THRESH);
    localparam logic [CNT_W-1:0] LO_C  = CNT_W'(LO_THRESH);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   out_q, out_nxt, rise_q, fall_q;
    logic                   in_sync;

    assign in_sync = sync[SYNC_STAGES-1];

    // Threshold decision uses the count before this strobe's update.
    always_comb begin
        cnt_nxt = cnt;
        if (in_sync && cnt != MAX_C)
            cnt_nxt = cnt + 1'b1;
        else if (!in_sync && cnt != '0)
            cnt_nxt = cnt - 1'b1;

        out_nxt = out_q;
        if (cnt >= HI_C)
            out_nxt = 1'b1;
        else if (cnt <= LO_C)
            out_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= {SYNC_STAGES{RL}};
            cnt    <= RL ? MAX_C : '0;
            out_q  <= RL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (samp_clk) begin
                sync   <= {sync[SYNC_STAGES-2:0], in};
                cnt    <= cnt_nxt;
                out_q  <= out_nxt;
                rise_q <= out_nxt & ~out_q;
                fall_q <= ~out_nxt & out_q;
            end
        end
    end

    assign q = '{out: out_q, rise: rise_q, fall: fall_q};

`ifdef UART_RX_FILTER_GLITCH_EN
    logic                prev_sync;
    logic [GLITCH_W-1:0] gcnt;

    // A glitch ended when the line returns to the level the filter held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sync <= RL;
            gcnt      <= '0;
        end else begin
            if (samp_clk)
                prev_sync <= in_sync;
            if (glitch_clr)
                gcnt <= '0;
            else if (samp_clk && (in_sync != prev_sync) && (in_sync == out_q) && gcnt != '1)
                gcnt <= gcnt + 1'b1;
        end
    end

    assign glitch_cnt = gcnt;
`endif

endmodule

// File: rtl/uart_rx_filter_bank.sv
// Bank of independent UART line deglitch filters, one uart_rx_filter_ch each.
// Optional glitch statistics enabled by defining UART_RX_FILTER_GLITCH_EN.
module uart_rx_filter_bank
    import uart_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int HI_THRESH   = max_cnt(CNT_W),
    parameter int LO_THRESH   = DEF_LO_THRESH,
    parameter int RESET_LEVEL = DEF_RESET_LEVEL
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         samp_clk,
    input  logic [CHANNELS-1:0]          in,
    output logic [CHANNELS-1:0]          out,
    output logic [CHANNELS-1:0]          rise,
    output logic [CHANNELS-1:0]          fall
`ifdef UART_RX_FILTER_GLITCH_EN
    ,
    input  logic                         glitch_clr,
    output logic [GLITCH_W*CHANNELS-1:0] glitch_cnt
`endif
);

    if (SYNC_STAGES < 2 || LO_THRESH < 0 || LO_THRESH >= HI_THRESH ||
        HI_THRESH > max_cnt(CNT_W)) begin : g_bad_cfg
        $error("uart_rx_filter_bank: invalid SYNC_STAGES or threshold parameters");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ch_out_t q;

        uart_rx_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .HI_THRESH   (HI_THRESH),
            .LO_THRESH   (LO_THRESH),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .samp_clk   (samp_clk),
            .in         (in[i]),
`ifdef UART_RX_FILTER_GLITCH_EN
            .glitch_clr (glitch_clr),
            .glitch_cnt (glitch_cnt[GLITCH_W*i +: GLITCH_W]),
`endif
            .q          (q)
        );

        assign out[i]  = q.out;
        assign rise[i] = q.rise;
        assign fall[i] = q.fall;
    end

endmodule

// File: doc/uart_rx_filter_bank.md
UART_RX_FILTER_BANK -- requirements
Module: uart_rx_filter_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 1: number of independent filtered inputs.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, minimum 2: synchroniser depth per channel.
REQ-003 SHALL have parameter CNT_W, default 2: deadband counter width; MAX = 2^CNT_W-1.
REQ-004 SHALL have parameter HI_THRESH, default MAX: count at or above which out goes high.
REQ-005 SHALL have parameter LO_THRESH, default 0: count at or below which out goes low.
REQ-006 SHALL have parameter RESET_LEVEL, default 1: UART idle (mark) level loaded at reset.
REQ-007 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-009 SHALL have port samp_clk  in  1  sample strobe; state advances only on clk edges where it is 1.
REQ-010 SHALL have port in  in  CHANNELS  raw asynchronous line inputs.
REQ-011 SHALL have port out  out  CHANNELS  filtered levels, registered.
REQ-012 SHALL have port rise  out  CHANNELS  one-clk pulse when out goes 0->1.
REQ-013 SHALL have port fall  out  CHANNELS  one-clk pulse when out goes 1->0.
REQ-014 SHALL have ports glitch_clr  in  1 and glitch_cnt  out  8*CHANNELS (channel i at bits 8i+7:8i), present only with UART_RX_FILTER_GLITCH_EN.

Function
REQ-015 SHALL, per channel on each strobe, shift in[i] through SYNC_STAGES flops; in_sync = last stage.
REQ-016 SHALL, on a strobe, increment cnt if in_sync=1 and cnt<MAX, decrement if in_sync=0 and cnt>0, else hold; never wrap.
REQ-017 SHALL, on a strobe, set out=1 if pre-update cnt>=HI_THRESH, out=0 if cnt<=LO_THRESH, else hold.
REQ-018 SHALL give latency, from in change before strobe 1 with cnt at 0, of out=1 at strobe SYNC_STAGES+HI_THRESH+1; symmetric for falling from MAX: strobe SYNC_STAGES+(MAX-LO_THRESH)+1.
REQ-019 SHALL assert rise/fall on the same clk edge out changes, clearing on the next clk edge regardless of samp_clk.
REQ-020 SHALL hold all state, and keep rise/fall low, on edges with samp_clk=0.
REQ-021 SHALL operate channels fully independently; no cross-channel interaction.
REQ-022 SHALL reject elaboration unless LO_THRESH < HI_THRESH <= MAX and SYNC_STAGES >= 2.

Reset
REQ-023 SHALL, while rst_n=0, force sync flops and out to RESET_LEVEL, cnt to MAX (RESET_LEVEL=1) or 0 (RESET_LEVEL=0), rise/fall and glitch_cnt to 0.
REQ-024 SHALL generate no rise/fall pulse on reset release or mid-operation reset.

Configuration
REQ-025 SHALL, with UART_RX_FILTER_GLITCH_EN defined, keep a per-channel 8-bit saturating counter incremented on strobes where in_sync differs from its previous-strobe value and equals out (rejected excursion ended).
REQ-026 SHALL clear all glitch counters synchronously on glitch_clr=1, clear taking priority over a coincident increment; counter holds at 255.
REQ-027 SHALL, without UART_RX_FILTER_GLITCH_EN, omit glitch_clr, glitch_cnt and all counter logic; other behaviour identical.

Structure
REQ-028 SHALL place parameter defaults and the glitch counter width (8) in shared package uart_pkg.
REQ-029 SHALL implement one channel in sub-module uart_rx_filter_ch, instantiated CHANNELS times by generate loop.

Verification
REQ-030 SHALL cover defaults, samp_clk=1 every cycle, in 1->0 held: out falls and fall pulses at strobe 6, one clk wide.
REQ-031 SHALL cover defaults, in low for 2 strobes then high: out stays 1, no fall, glitch_cnt=1 (GLITCH_EN).
REQ-032 SHALL cover samp_clk every 4th cycle, in toggled between strobes: no state change between strobes; latency counted in strobes only.
REQ-033 SHALL cover CHANNELS=4, CNT_W=3, HI=5, LO=2: channel 2 driven alone, others stay 1; out[2] rises at strobe SYNC_STAGES+HI_THRESH+1 from cnt 0.
REQ-034 SHALL cover rst_n pulsed low mid-transition: out=1, cnt=MAX, no rise/fall; glitch_clr with coincident increment -> 0; 300 glitches -> 255.
